// File: rtl/dram_page_ctrl_fsm.sv
// rtl/dram_page_ctrl_fsm.sv - open-page DRAM command sequencer
// Tracks the open row per bank, issues PRE/ACT only on page miss, column bursts with in-row wrap, PREA/REF refresh.
module dram_page_ctrl_fsm #(
  parameter int NUMBER_OF_BANKS = 8,
  parameter int NUMBER_OF_ROWS  = 128,
  parameter int NUMBER_OF_COLS  = 8,
  parameter int BURST_LEN       = 4,
  parameter int TRP             = 2,
  parameter int TRCD            = 2,
  parameter int TRFC            = 8,
  localparam int BW = $clog2(NUMBER_OF_BANKS),
  localparam int RW = $clog2(NUMBER_OF_ROWS),
  localparam int CW = $clog2(NUMBER_OF_COLS)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          addr_val,
  input  logic          rw,
  input  logic [BW-1:0] bank_id,
  input  logic [RW-1:0] row_id,
  input  logic [CW-1:0] col_id,
  input  logic          refresh_flag,
  input  logic          cmd_ack,
  output logic          addr_ack,
  output logic          cmd_req,
  output logic [2:0]    cmd,
  output logic [BW-1:0] cmd_bank,
  output logic [RW-1:0] cmd_row,
  output logic [CW-1:0] cmd_col,
  output logic          busy,
  output logic          refresh_done
);
  localparam int TMAX = (TRFC > TRP) ? ((TRFC > TRCD) ? TRFC : TRCD) : ((TRP > TRCD) ? TRP : TRCD);
  localparam int WW   = $clog2(TMAX) + 1;
  localparam int KW   = $clog2(BURST_LEN) + 1;

  localparam logic [2:0] CMD_NOP  = 3'd0;
  localparam logic [2:0] CMD_ACT  = 3'd1;
  localparam logic [2:0] CMD_RD   = 3'd2;
  localparam logic [2:0] CMD_WR   = 3'd3;
  localparam logic [2:0] CMD_PRE  = 3'd4;
  localparam logic [2:0] CMD_PREA = 3'd5;
  localparam logic [2:0] CMD_REF  = 3'd6;

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_PRE_WAIT, S_ACT, S_ACT_WAIT, S_COL,
    S_REF_PREA, S_PREA_WAIT, S_REF_CMD, S_REF_WAIT
  } state_t;

  state_t                      state_q, state_d;
  logic [WW-1:0]               wait_q, wait_d;
  logic [KW-1:0]               beat_q, beat_d;
  logic                        rw_q, rw_d;
  logic [BW-1:0]               bank_q, bank_d;
  logic [RW-1:0]               row_q, row_d;
  logic [CW-1:0]               col_q, col_d;
  logic [NUMBER_OF_BANKS-1:0]  open_valid_q, open_valid_d;
  logic [RW-1:0]               open_row_q [NUMBER_OF_BANKS];
  logic [RW-1:0]               open_row_d [NUMBER_OF_BANKS];
  logic                        refresh_pend_q, refresh_pend_d;
  logic                        addr_ack_q, addr_ack_d;
  logic                        cmd_req_q, cmd_req_d;
  logic [2:0]                  cmd_q, cmd_d;
  logic [BW-1:0]               cmd_bank_q, cmd_bank_d;
  logic [RW-1:0]               cmd_row_q, cmd_row_d;
  logic [CW-1:0]               cmd_col_q, cmd_col_d;
  logic                        busy_q, busy_d;
  logic                        refresh_done_q, refresh_done_d;
  logic                        ack, refresh_req, capture;

  assign ack         = cmd_req_q & cmd_ack;
  assign refresh_req = refresh_pend_q | refresh_flag;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q        <= S_IDLE;
      wait_q         <= '0;
      beat_q         <= '0;
      rw_q           <= 1'b0;
      bank_q         <= '0;
      row_q          <= '0;
      col_q          <= '0;
      open_valid_q   <= '0;
      for (int i = 0; i < NUMBER_OF_BANKS; i++) open_row_q[i] <= '0;
      refresh_pend_q <= 1'b0;
      addr_ack_q     <= 1'b0;
      cmd_req_q      <= 1'b0;
      cmd_q          <= CMD_NOP;
      cmd_bank_q     <= '0;
      cmd_row_q      <= '0;
      cmd_col_q      <= '0;
      busy_q         <= 1'b0;
      refresh_done_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_q         <= wait_d;
      beat_q         <= beat_d;
      rw_q           <= rw_d;
      bank_q         <= bank_d;
      row_q          <= row_d;
      col_q          <= col_d;
      open_valid_q   <= open_valid_d;
      open_row_q     <= open_row_d;
      refresh_pend_q <= refresh_pend_d;
      addr_ack_q     <= addr_ack_d;
      cmd_req_q      <= cmd_req_d;
      cmd_q          <= cmd_d;
      cmd_bank_q     <= cmd_bank_d;
      cmd_row_q      <= cmd_row_d;
      cmd_col_q      <= cmd_col_d;
      busy_q         <= busy_d;
      refresh_done_q <= refresh_done_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    beat_d         = beat_q;
    rw_d           = rw_q;
    bank_d         = bank_q;
    row_d          = row_q;
    col_d          = col_q;
    open_valid_d   = open_valid_q;
    open_row_d     = open_row_q;
    refresh_pend_d = refresh_pend_q | refresh_flag;
    capture        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (refresh_req) begin
          state_d = (|open_valid_q) ? S_REF_PREA : S_REF_CMD;
        end else if (addr_val) begin
          capture = 1'b1;
          rw_d    = rw;
          bank_d  = bank_id;
          row_d   = row_id;
          col_d   = col_id;
          beat_d  = '0;
          if (open_valid_q[bank_id]) state_d = (open_row_q[bank_id] == row_id) ? S_COL : S_PRE;
          else                       state_d = S_ACT;
        end
      end
      S_PRE: if (ack) begin
        open_valid_d[bank_q] = 1'b0;
        wait_d               = WW'(TRP - 1);
        state_d              = S_PRE_WAIT;
      end
      S_ACT: if (ack) begin
        open_valid_d[bank_q] = 1'b1;
        open_row_d[bank_q]   = row_q;
        wait_d               = WW'(TRCD - 1);
        state_d              = S_ACT_WAIT;
      end
      S_COL: if (ack) begin
        // Column wraps inside the row by natural CW-bit overflow.
        col_d = col_q + CW'(1);
        if (beat_q == KW'(BURST_LEN - 1)) state_d = S_IDLE;
        else                              beat_d  = beat_q + KW'(1);
      end
      S_REF_PREA: if (ack) begin
        open_valid_d = '0;
        wait_d       = WW'(TRP - 1);
        state_d      = S_PREA_WAIT;
      end
      S_REF_CMD: if (ack) begin
        refresh_pend_d = refresh_flag;
        wait_d         = WW'(TRFC - 1);
        state_d        = S_REF_WAIT;
      end
      S_PRE_WAIT, S_ACT_WAIT, S_PREA_WAIT, S_REF_WAIT: begin
        if (wait_q == '0) begin
          case (state_q)
            S_PRE_WAIT:  state_d = S_ACT;
            S_ACT_WAIT:  state_d = S_COL;
            S_PREA_WAIT: state_d = S_REF_CMD;
            default:     state_d = S_IDLE;
          endcase
        end else begin
          wait_d = wait_q - WW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A command is held until acked; the ack cycle drops cmd_req so every command sees a low gap.
  always_comb begin
    cmd_req_d      = 1'b0;
    cmd_d          = CMD_NOP;
    cmd_bank_d     = '0;
    cmd_row_d      = '0;
    cmd_col_d      = '0;
    addr_ack_d     = capture;
    busy_d         = (state_d != S_IDLE);
    refresh_done_d = (state_q == S_REF_WAIT) && (state_d == S_IDLE);
    if (!ack) begin
      case (state_q)
        S_PRE:      begin cmd_req_d = 1'b1; cmd_d = CMD_PRE; cmd_bank_d = bank_q; end
        S_ACT:      begin cmd_req_d = 1'b1; cmd_d = CMD_ACT; cmd_bank_d = bank_q; cmd_row_d = row_q; end
        S_COL:      begin
          cmd_req_d  = 1'b1;
          cmd_d      = rw_q ? CMD_WR : CMD_RD;
          cmd_bank_d = bank_q;
          cmd_col_d  = col_q;
        end
        S_REF_PREA: begin cmd_req_d = 1'b1; cmd_d = CMD_PREA; end
        S_REF_CMD:  begin cmd_req_d = 1'b1; cmd_d = CMD_REF; end
        default:    ;
      endcase
    end
  end

  assign addr_ack     = addr_ack_q;
  assign cmd_req      = cmd_req_q;
  assign cmd          = cmd_q;
  assign cmd_bank     = cmd_bank_q;
  assign cmd_row      = cmd_row_q;
  assign cmd_col      = cmd_col_q;
  assign busy         = busy_q;
  assign refresh_done = refresh_done_q;
endmodule
